// File: rtl/ranked_leaderboard.sv
// Top-N leaderboard with FAST (lower is better) and SLOW (higher is better) boards,
// sorted insertion over a valid/ready handshake, rank sound strobe and registered display read port.
module ranked_leaderboard #(
  parameter int TIME_W    = 39,
  parameter int DEPTH     = 3,
  parameter int SOUND_CYC = 50_000_000,
  localparam int RANK_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              time_valid,
  output logic              time_ready,
  input  logic [TIME_W-1:0] time_in,
  input  logic [1:0]        stopwatch_mode,
  input  logic              clear_board,
  input  logic              disp_board,
  input  logic [RANK_W-1:0] disp_rank,
  output logic [TIME_W-1:0] disp_time,
  output logic              disp_valid,
  output logic [DEPTH-1:0]  rank_led,
  output logic              placed,
  output logic [RANK_W-1:0] placed_rank,
  output logic [DEPTH-1:0]  sound
);

  localparam int CNT_W = $clog2(SOUND_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_INSERT, S_ANNOUNCE} state_t;

  state_t            state;
  logic [TIME_W-1:0] lat_time;
  logic [1:0]        lat_mode;
  logic [TIME_W-1:0] board_time [2][DEPTH];
  logic [DEPTH-1:0]  board_valid [2];
  logic [CNT_W-1:0]  sound_cnt;

  logic              sel;
  logic              mode_ok;
  logic [DEPTH-1:0]  beats;
  logic              ins_hit;
  logic [RANK_W-1:0] ins_k;
  logic              disp_in_range;
  logic [DEPTH-1:0]  led_next;

  // Board index 0 is FAST, 1 is SLOW, matching disp_board.
  always_comb begin
    sel     = (lat_mode == 2'b01);
    mode_ok = (lat_mode == 2'b01) || (lat_mode == 2'b10);
    beats   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      beats[i] = !board_valid[sel][i] ||
                 (sel ? (lat_time > board_time[sel][i]) : (lat_time < board_time[sel][i]));
    end
    ins_hit = 1'b0;
    ins_k   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!ins_hit && beats[i]) begin
        ins_hit = 1'b1;
        ins_k   = RANK_W'(i);
      end
    end
  end

  always_comb begin
    disp_in_range = ({1'b0, disp_rank} < (RANK_W + 1)'(DEPTH));
    led_next      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      led_next[i] = disp_in_range && (disp_rank >= RANK_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      time_ready  <= 1'b1;
      lat_time    <= '0;
      lat_mode    <= '0;
      placed      <= 1'b0;
      placed_rank <= '0;
      sound       <= '0;
      sound_cnt   <= '0;
      disp_time   <= '0;
      disp_valid  <= 1'b0;
      rank_led    <= '0;
      for (int unsigned b = 0; b < 2; b++) begin
        board_valid[b] <= '0;
        for (int unsigned i = 0; i < DEPTH; i++) board_time[b][i] <= '0;
      end
    end else begin
      if (disp_in_range) begin
        disp_time  <= board_time[disp_board][disp_rank];
        disp_valid <= board_valid[disp_board][disp_rank];
      end else begin
        disp_time  <= '0;
        disp_valid <= 1'b0;
      end
      rank_led <= led_next;
      placed   <= 1'b0;

      if (sound_cnt != '0) begin
        sound_cnt <= sound_cnt - CNT_W'(1);
        if (sound_cnt == CNT_W'(1)) sound <= '0;
      end

      if (clear_board) begin
        state      <= S_IDLE;
        time_ready <= 1'b1;
        sound      <= '0;
        sound_cnt  <= '0;
        for (int unsigned b = 0; b < 2; b++) begin
          board_valid[b] <= '0;
          for (int unsigned i = 0; i < DEPTH; i++) board_time[b][i] <= '0;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (time_valid && time_ready) begin
              lat_time   <= time_in;
              lat_mode   <= stopwatch_mode;
              time_ready <= 1'b0;
              state      <= S_INSERT;
            end
          end
          S_INSERT: begin
            // Board write and announce outputs share this edge so placed lands in ANNOUNCE.
            if (mode_ok && ins_hit) begin
              for (int unsigned i = 1; i < DEPTH; i++) begin
                if (RANK_W'(i) > ins_k) begin
                  board_time[sel][i]  <= board_time[sel][i-1];
                  board_valid[sel][i] <= board_valid[sel][i-1];
                end
              end
              board_time[sel][ins_k]  <= lat_time;
              board_valid[sel][ins_k] <= 1'b1;
              placed      <= 1'b1;
              placed_rank <= ins_k;
              sound       <= DEPTH'(1) << ins_k;
              sound_cnt   <= CNT_W'(SOUND_CYC);
            end
            state <= S_ANNOUNCE;
          end
          S_ANNOUNCE: begin
            time_ready <= 1'b1;
            state      <= S_IDLE;
          end
          default: begin
            time_ready <= 1'b1;
            state      <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ranked_leaderboard.sv
// Directed bench for ranked_leaderboard: DEPTH=3, TIME_W=39, short sound strobe of 4 cycles.
module tb_ranked_leaderboard;
  localparam int TW = 39;
  localparam int D  = 3;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          time_valid;
  logic          time_ready;
  logic [TW-1:0] time_in;
  logic [1:0]    stopwatch_mode;
  logic          clear_board;
  logic          disp_board;
  logic [RW-1:0] disp_rank;
  logic [TW-1:0] disp_time;
  logic          disp_valid;
  logic [D-1:0]  rank_led;
  logic          placed;
  logic [RW-1:0] placed_rank;
  logic [D-1:0]  sound;

  ranked_leaderboard #(.TIME_W(TW), .DEPTH(D), .SOUND_CYC(4)) dut (
    .clk(clk), .reset(reset), .time_valid(time_valid), .time_ready(time_ready),
    .time_in(time_in), .stopwatch_mode(stopwatch_mode), .clear_board(clear_board),
    .disp_board(disp_board), .disp_rank(disp_rank), .disp_time(disp_time),
    .disp_valid(disp_valid), .rank_led(rank_led), .placed(placed),
    .placed_rank(placed_rank), .sound(sound)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int placed_cnt = 0;

  always @(negedge clk) if (placed === 1'b1) placed_cnt++;

  logic          got_placed;
  logic [RW-1:0] got_rank;
  logic [D-1:0]  got_sound;
  logic [TW-1:0] rd_time;
  logic          rd_valid;
  logic [D-1:0]  rd_led;

  // All helpers start and end on a falling edge.
  task automatic push(input logic [1:0] mode, input logic [TW-1:0] t);
    int w = 0;
    while (time_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (time_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL push_ready_timeout got=%b exp=1", time_ready);
    end
    time_valid = 1'b1; stopwatch_mode = mode; time_in = t;
    @(negedge clk);
    time_valid = 1'b0;
    @(negedge clk);
    got_placed = placed; got_rank = placed_rank; got_sound = sound;
    @(negedge clk);
  endtask

  task automatic read_entry(input logic b, input logic [RW-1:0] r);
    disp_board = b; disp_rank = r;
    @(negedge clk);
    rd_time = disp_time; rd_valid = disp_valid; rd_led = rank_led;
  endtask

  task automatic clear_pulse();
    clear_board = 1'b1;
    @(negedge clk);
    clear_board = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (time_ready !== 1'b1 || placed !== 1'b0 || placed_rank !== 2'd0 || sound !== 3'b000 ||
        disp_time !== '0 || disp_valid !== 1'b0 || rank_led !== 3'b000) begin
      failures++;
      $display("FAIL reset_values got ready=%b placed=%b rank=%0d sound=%b time=%0d valid=%b led=%b exp 1 0 0 000 0 0 000",
               time_ready, placed, placed_rank, sound, disp_time, disp_valid, rank_led);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_slow_insert();
    int tv[3] = '{100, 300, 200};
    int er[3] = '{0, 0, 1};
    int es[3] = '{1, 1, 2};
    int eb[3] = '{300, 200, 100};
    for (int i = 0; i < 3; i++) begin
      push(2'b01, TW'(tv[i]));
      checks++;
      if (got_placed !== 1'b1 || got_rank !== RW'(er[i]) || got_sound !== D'(es[i])) begin
        failures++;
        $display("FAIL slow_place_%0d got placed=%b rank=%0d sound=%b exp 1 %0d %b",
                 i, got_placed, got_rank, got_sound, er[i], D'(es[i]));
      end
    end
    for (int r = 0; r < 3; r++) begin
      read_entry(1'b1, RW'(r));
      checks++;
      if (rd_time !== TW'(eb[r]) || rd_valid !== 1'b1) begin
        failures++;
        $display("FAIL slow_board_%0d got=%0d/%b exp=%0d/1", r, rd_time, rd_valid, eb[r]);
      end
    end
  endtask

  task automatic test_fast_full();
    int eb[3] = '{10, 20, 25};
    int base;
    clear_pulse();
    push(2'b10, 20); push(2'b10, 30); push(2'b10, 10);
    push(2'b10, 25);
    checks++;
    if (got_placed !== 1'b1 || got_rank !== 2'd2) begin
      failures++;
      $display("FAIL fast_push25 got placed=%b rank=%0d exp 1 2", got_placed, got_rank);
    end
    base = placed_cnt;
    push(2'b10, 40);
    @(negedge clk);
    checks++;
    if (got_placed !== 1'b0 || placed_cnt != base) begin
      failures++;
      $display("FAIL fast_push40 got placed=%b pulses=%0d exp 0 %0d", got_placed, placed_cnt, base);
    end
    for (int r = 0; r < 3; r++) begin
      read_entry(1'b0, RW'(r));
      checks++;
      if (rd_time !== TW'(eb[r]) || rd_valid !== 1'b1 || rd_led !== D'((1 << (r + 1)) - 1)) begin
        failures++;
        $display("FAIL fast_board_%0d got=%0d/%b/%b exp=%0d/1", r, rd_time, rd_valid, rd_led, eb[r]);
      end
    end
    read_entry(1'b0, 2'd3);
    checks++;
    if (rd_time !== '0 || rd_valid !== 1'b0 || rd_led !== 3'b000) begin
      failures++;
      $display("FAIL disp_out_of_range got=%0d/%b/%b exp=0/0/000", rd_time, rd_valid, rd_led);
    end
  endtask

  task automatic test_tie();
    clear_pulse();
    push(2'b10, 10); push(2'b10, 20);
    read_entry(1'b0, 2'd2);
    checks++;
    if (rd_time !== '0 || rd_valid !== 1'b0 || rd_led !== 3'b111) begin
      failures++;
      $display("FAIL tie_empty_slot got=%0d/%b/%b exp=0/0/111", rd_time, rd_valid, rd_led);
    end
    push(2'b10, 20);
    checks++;
    if (got_placed !== 1'b1 || got_rank !== 2'd2) begin
      failures++;
      $display("FAIL tie_place got placed=%b rank=%0d exp 1 2", got_placed, got_rank);
    end
    read_entry(1'b0, 2'd2);
    checks++;
    if (rd_time !== TW'(20) || rd_valid !== 1'b1 || rd_led !== 3'b111) begin
      failures++;
      $display("FAIL tie_rank2 got=%0d/%b/%b exp=20/1/111", rd_time, rd_valid, rd_led);
    end
  endtask

  task automatic test_discard();
    push(2'b11, 5);
    checks++;
    if (got_placed !== 1'b0) begin
      failures++;
      $display("FAIL discard_11 got placed=%b exp 0", got_placed);
    end
    push(2'b00, 5);
    checks++;
    if (got_placed !== 1'b0) begin
      failures++;
      $display("FAIL discard_00 got placed=%b exp 0", got_placed);
    end
    read_entry(1'b0, 2'd0);
    checks++;
    if (rd_time !== TW'(10)) begin
      failures++;
      $display("FAIL discard_board got=%0d exp=10", rd_time);
    end
  endtask

  task automatic test_back_to_back();
    int tv[3] = '{30, 10, 20};
    int eb[3] = '{10, 20, 30};
    int acc = 0;
    int base;
    clear_pulse();
    base = placed_cnt;
    stopwatch_mode = 2'b10; time_valid = 1'b1; time_in = TW'(tv[0]);
    for (int c = 0; c < 9; c++) begin
      checks++;
      if (time_ready !== ((c % 3) == 0)) begin
        failures++;
        $display("FAIL b2b_ready_c%0d got=%b exp=%b", c, time_ready, ((c % 3) == 0));
      end
      if (time_ready === 1'b1 && acc < 3) begin
        time_in = TW'(tv[acc]);
        acc++;
      end
      @(negedge clk);
    end
    time_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (placed_cnt - base != 3) begin
      failures++;
      $display("FAIL b2b_pulses got=%0d exp=3", placed_cnt - base);
    end
    for (int r = 0; r < 3; r++) begin
      read_entry(1'b0, RW'(r));
      checks++;
      if (rd_time !== TW'(eb[r]) || rd_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b_board_%0d got=%0d/%b exp=%0d/1", r, rd_time, rd_valid, eb[r]);
      end
    end
  endtask

  task automatic test_clear_abort();
    int base;
    clear_pulse();
    push(2'b01, 50);
    base = placed_cnt;
    time_valid = 1'b1; stopwatch_mode = 2'b01; time_in = TW'(70);
    @(negedge clk);
    time_valid = 1'b0; clear_board = 1'b1;
    @(negedge clk);
    clear_board = 1'b0;
    checks++;
    if (time_ready !== 1'b1 || placed !== 1'b0 || sound !== 3'b000) begin
      failures++;
      $display("FAIL clear_abort_outputs got ready=%b placed=%b sound=%b exp 1 0 000",
               time_ready, placed, sound);
    end
    @(negedge clk);
    checks++;
    if (placed_cnt != base) begin
      failures++;
      $display("FAIL clear_abort_pulse got=%0d exp=%0d", placed_cnt, base);
    end
    read_entry(1'b1, 2'd0);
    checks++;
    if (rd_time !== '0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_slow_empty got=%0d/%b exp=0/0", rd_time, rd_valid);
    end
    read_entry(1'b0, 2'd0);
    checks++;
    if (rd_time !== '0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_fast_empty got=%0d/%b exp=0/0", rd_time, rd_valid);
    end
  endtask

  task automatic test_sound();
    int es[10] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 0};
    clear_pulse();
    stopwatch_mode = 2'b10;
    for (int c = 0; c < 10; c++) begin
      if (c != 0) begin
        checks++;
        if (sound !== D'(es[c])) begin
          failures++;
          $display("FAIL sound_c%0d got=%b exp=%b", c, sound, D'(es[c]));
        end
      end
      if (c == 3) begin
        checks++;
        if (time_ready !== 1'b1) begin
          failures++;
          $display("FAIL sound_ready got=%b exp=1", time_ready);
        end
      end
      time_valid = (c == 0) || (c == 3);
      time_in    = (c == 0) ? TW'(100) : TW'(200);
      @(negedge clk);
    end
    time_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; time_valid = 1'b0; time_in = '0; stopwatch_mode = 2'b00;
    clear_board = 1'b0; disp_board = 1'b0; disp_rank = '0;
    test_reset();
    test_slow_insert();
    test_fast_full();
    test_tie();
    test_discard();
    test_back_to_back();
    test_clear_abort();
    test_sound();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
